pipe_hazard_ctrl: RTL and testbench

- Control-side partner of the ID/EX pipeline register in the 5-stage MIPS pipeline.
- Consumes the ID-stage decode and the EX/MEM/WB control fields carried down the pipe.
- Drives the register write-enables and bubbles back into IF/ID and ID/EX.
- Generates EX-stage operand forwarding selects, sequences a fixed-latency multiply/divide stall, and keeps stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control beside the ID/EX register: forwarding selects, load-use
// and mult/div stalls, branch flushes, and stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UseRs,
    input  logic             ID_UseRt,
    input  logic             ID_MulDivStart,
    input  logic [4:0]       EX_rs,
    input  logic [4:0]       EX_rt,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_dst,
    input  logic             EX_BranchTaken,
    input  logic             MEM_RegWrite,
    input  logic [4:0]       MEM_dst,
    input  logic             WB_RegWrite,
    input  logic [4:0]       WB_dst,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             MulDivBusy,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0]       LAT     = 4'(MULDIV_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     state;
    logic [3:0] cnt;
    logic       busy;
    logic       lu;
    logic       start_ok;
    logic       ex_wr_unused;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_wr,
        input logic [4:0] mem_dst,
        input logic       wb_wr,
        input logic [4:0] wb_dst
    );
        if (mem_wr && mem_dst != 5'd0 && mem_dst == src)
            return 2'b01;
        else if (wb_wr && wb_dst != 5'd0 && wb_dst == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // EX_RegWrite is implied by EX_MemRead for a load; not needed here.
    assign ex_wr_unused = EX_RegWrite;

    assign busy = (state == BUSY);

    assign lu = EX_MemRead && (EX_dst != 5'd0) &&
                ((ID_UseRs && ID_rs == EX_dst) ||
                 (ID_UseRt && ID_rt == EX_dst));

    assign start_ok = !busy && ID_MulDivStart &&
                      !lu && !EX_BranchTaken;

    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        priority case (1'b1)
            rst: begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end
            busy: begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                IF_ID_Flush = EX_BranchTaken;
                ID_EX_Flush = 1'b1;
            end
            EX_BranchTaken: begin
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
            end
            lu: begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end
            default: begin
                PC_Write    = 1'b1;
                IF_ID_Write = 1'b1;
            end
        endcase
    end

    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (!rst) begin
            ForwardA = fwd_sel(EX_rs, MEM_RegWrite, MEM_dst,
                               WB_RegWrite, WB_dst);
            ForwardB = fwd_sel(EX_rt, MEM_RegWrite, MEM_dst,
                               WB_RegWrite, WB_dst);
        end
    end

    assign MulDivBusy = busy && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        state <= BUSY;
                        cnt   <= LAT;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (!PC_Write && StallCycles != CNT_MAX)
                StallCycles <= StallCycles + CNT_ONE;
            if (EX_BranchTaken && FlushCount != CNT_MAX)
                FlushCount <= FlushCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EX_rs, EX_rt, EX_dst, MEM_dst, WB_dst;
    logic       ID_UseRs, ID_UseRt, ID_MulDivStart;
    logic       EX_MemRead, EX_RegWrite, EX_BranchTaken;
    logic       MEM_RegWrite, WB_RegWrite;

    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
    logic [1:0]  ForwardA, ForwardB;
    logic        MulDivBusy;
    logic [31:0] StallCycles, FlushCount;

    logic        pc_s, ifw_s, iff_s, idf_s, busy_s;
    logic [1:0]  fa_s, fb_s;
    logic [3:0]  stall_s, flush_s;

    int n_tests = 0;
    int n_fail  = 0;

    int     m_busy;
    longint m_stall, m_flush;
    int     m_stall4, m_flush4;

    logic       e_pc, e_ifw, e_iff, e_idf, e_busy, e_lu;
    logic [1:0] e_fa, e_fb;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_MulDivStart(ID_MulDivStart),
        .EX_rs(EX_rs), .EX_rt(EX_rt),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
        .EX_dst(EX_dst), .EX_BranchTaken(EX_BranchTaken),
        .MEM_RegWrite(MEM_RegWrite), .MEM_dst(MEM_dst),
        .WB_RegWrite(WB_RegWrite), .WB_dst(WB_dst),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .MulDivBusy(MulDivBusy),
        .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_MulDivStart(ID_MulDivStart),
        .EX_rs(EX_rs), .EX_rt(EX_rt),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
        .EX_dst(EX_dst), .EX_BranchTaken(EX_BranchTaken),
        .MEM_RegWrite(MEM_RegWrite), .MEM_dst(MEM_dst),
        .WB_RegWrite(WB_RegWrite), .WB_dst(WB_dst),
        .PC_Write(pc_s), .IF_ID_Write(ifw_s),
        .IF_ID_Flush(iff_s), .ID_EX_Flush(idf_s),
        .ForwardA(fa_s), .ForwardB(fb_s),
        .MulDivBusy(busy_s),
        .StallCycles(stall_s), .FlushCount(flush_s)
    );

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (MEM_RegWrite && MEM_dst != 0 && MEM_dst == src) return 2'b01;
        if (WB_RegWrite && WB_dst != 0 && WB_dst == src) return 2'b10;
        return 2'b00;
    endfunction

    // Expected combinational outputs from the current inputs and model.
    function void compute();
        e_lu = EX_MemRead && EX_dst != 0 &&
               ((ID_UseRs && ID_rs == EX_dst) ||
                (ID_UseRt && ID_rt == EX_dst));
        e_fa = 2'b00;
        e_fb = 2'b00;
        e_busy = 1'b0;
        if (rst) begin
            {e_pc, e_ifw, e_iff, e_idf} = 4'b0011;
        end else begin
            e_fa = ref_fwd(EX_rs);
            e_fb = ref_fwd(EX_rt);
            e_busy = (m_busy > 0);
            if (m_busy > 0)
                {e_pc, e_ifw, e_iff, e_idf} = {3'b000, EX_BranchTaken} << 1 | 4'b0001;
            else if (EX_BranchTaken)
                {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
            else if (e_lu)
                {e_pc, e_ifw, e_iff, e_idf} = 4'b0001;
            else
                {e_pc, e_ifw, e_iff, e_idf} = 4'b1100;
        end
    endfunction

    task automatic advance();
        compute();
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_stall = 0; m_flush = 0;
            m_stall4 = 0; m_flush4 = 0;
        end else begin
            if (!e_pc) begin
                if (m_stall < 64'hFFFF_FFFF) m_stall++;
                if (m_stall4 < 15) m_stall4++;
            end
            if (EX_BranchTaken) begin
                if (m_flush < 64'hFFFF_FFFF) m_flush++;
                if (m_flush4 < 15) m_flush4++;
            end
            if (m_busy > 0) m_busy--;
            else if (ID_MulDivStart && !e_lu && !EX_BranchTaken) m_busy = LAT;
        end
        #1;
    endtask

    task automatic idle_inputs();
        ID_rs = 0; ID_rt = 0; ID_UseRs = 0; ID_UseRt = 0;
        ID_MulDivStart = 0; EX_rs = 0; EX_rt = 0;
        EX_MemRead = 0; EX_RegWrite = 0; EX_dst = 0;
        EX_BranchTaken = 0; MEM_RegWrite = 0; MEM_dst = 0;
        WB_RegWrite = 0; WB_dst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        MEM_RegWrite = 1; MEM_dst = 5; EX_rs = 5;
        advance();
        advance();
        @(negedge clk);
        n_tests++;
        if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0011",
                     {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush});
        end
        n_tests++;
        if (ForwardA !== 2'b00 || MulDivBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fwd_busy: got fa=%b busy=%b want 00/0",
                     ForwardA, MulDivBusy);
        end
        n_tests++;
        if (StallCycles !== 0 || FlushCount !== 0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0",
                     StallCycles, FlushCount);
        end
        rst = 0;
        idle_inputs();
        advance();
    endtask

    task automatic test_load_use();
        EX_MemRead = 1; EX_RegWrite = 1; EX_dst = 2;
        ID_rs = 2; ID_UseRs = 1;
        @(negedge clk);
        n_tests++;
        if ({PC_Write, IF_ID_Write, ID_EX_Flush} !== 3'b001) begin
            n_fail++;
            $display("FAIL lu_stall: got %b want 001",
                     {PC_Write, IF_ID_Write, ID_EX_Flush});
        end
        advance();
        EX_MemRead = 0;
        @(negedge clk);
        n_tests++;
        if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b1100) begin
            n_fail++;
            $display("FAIL lu_release: got %b want 1100",
                     {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush});
        end
        n_tests++;
        if (StallCycles !== 32'd1) begin
            n_fail++;
            $display("FAIL lu_count: got %0d want 1", StallCycles);
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_forwarding();
        EX_rs = 5; MEM_RegWrite = 1; MEM_dst = 5;
        WB_RegWrite = 1; WB_dst = 5;
        @(negedge clk);
        n_tests++;
        if (ForwardA !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_mem_prio: got %b want 01", ForwardA);
        end
        MEM_dst = 0; WB_dst = 0; EX_rs = 0;
        #1;
        n_tests++;
        if (ForwardA !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_r0: got %b want 00", ForwardA);
        end
        EX_rt = 7; WB_dst = 7; MEM_dst = 3;
        #1;
        n_tests++;
        if (ForwardB !== 2'b10 || ForwardA !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_wb: got a=%b b=%b want 00/10",
                     ForwardA, ForwardB);
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_muldiv();
        longint s0;
        s0 = m_stall;
        ID_MulDivStart = 1;
        @(negedge clk);
        n_tests++;
        if (PC_Write !== 1'b1 || MulDivBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL md_accept: got pc=%b busy=%b want 1/0",
                     PC_Write, MulDivBusy);
        end
        advance();
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            n_tests++;
            if ({MulDivBusy, PC_Write, IF_ID_Write, ID_EX_Flush} !== 4'b1001) begin
                n_fail++;
                $display("FAIL md_busy%0d: got %b want 1001", i,
                         {MulDivBusy, PC_Write, IF_ID_Write, ID_EX_Flush});
            end
            advance();
            ID_MulDivStart = 0;
        end
        @(negedge clk);
        n_tests++;
        if (MulDivBusy !== 1'b0 || PC_Write !== 1'b1) begin
            n_fail++;
            $display("FAIL md_done: got busy=%b pc=%b want 0/1",
                     MulDivBusy, PC_Write);
        end
        n_tests++;
        if (StallCycles !== 32'(s0 + LAT)) begin
            n_fail++;
            $display("FAIL md_stalls: got %0d want %0d",
                     StallCycles, s0 + LAT);
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_branch_priority();
        longint f0;
        f0 = m_flush;
        EX_MemRead = 1; EX_dst = 3; ID_rs = 3; ID_UseRs = 1;
        ID_MulDivStart = 1; EX_BranchTaken = 1;
        @(negedge clk);
        n_tests++;
        if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 4'b1111) begin
            n_fail++;
            $display("FAIL br_prio: got %b want 1111",
                     {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush});
        end
        advance();
        idle_inputs();
        @(negedge clk);
        n_tests++;
        if (MulDivBusy !== 1'b0 || FlushCount !== 32'(f0 + 1)) begin
            n_fail++;
            $display("FAIL br_squash: got busy=%b flush=%0d want 0/%0d",
                     MulDivBusy, FlushCount, f0 + 1);
        end
        advance();
    endtask

    task automatic test_branch_during_busy();
        longint f0;
        ID_MulDivStart = 1;
        advance();
        ID_MulDivStart = 0;
        EX_BranchTaken = 1;
        f0 = m_flush;
        @(negedge clk);
        n_tests++;
        if ({MulDivBusy, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush} !== 5'b10011) begin
            n_fail++;
            $display("FAIL br_busy: got %b want 10011",
                     {MulDivBusy, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush});
        end
        advance();
        EX_BranchTaken = 0;
        for (int i = 1; i < LAT; i++) advance();
        @(negedge clk);
        n_tests++;
        if (MulDivBusy !== 1'b0 || FlushCount !== 32'(f0 + 1)) begin
            n_fail++;
            $display("FAIL br_busy_end: got busy=%b flush=%0d want 0/%0d",
                     MulDivBusy, FlushCount, f0 + 1);
        end
        advance();
    endtask

    task automatic test_reset_mid_busy();
        ID_MulDivStart = 1;
        advance();
        ID_MulDivStart = 0;
        advance();
        rst = 1;
        @(negedge clk);
        n_tests++;
        if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDivBusy} !== 5'b00110) begin
            n_fail++;
            $display("FAIL rst_busy_force: got %b want 00110",
                     {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDivBusy});
        end
        advance();
        @(negedge clk);
        n_tests++;
        if (MulDivBusy !== 1'b0 || StallCycles !== 0 || FlushCount !== 0) begin
            n_fail++;
            $display("FAIL rst_busy_clear: got busy=%b s=%0d f=%0d want 0/0/0",
                     MulDivBusy, StallCycles, FlushCount);
        end
        rst = 0;
        advance();
        @(negedge clk);
        n_tests++;
        if (MulDivBusy !== 1'b0 || PC_Write !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_busy_idle: got busy=%b pc=%b want 0/1",
                     MulDivBusy, PC_Write);
        end
        advance();
    endtask

    task automatic test_saturation();
        EX_MemRead = 1; EX_dst = 4; ID_rt = 4; ID_UseRt = 1;
        for (int i = 0; i < 20; i++) begin
            advance();
            @(negedge clk);
            n_tests++;
            if (stall_s !== 4'(m_stall4) || StallCycles !== 32'(m_stall)) begin
                n_fail++;
                $display("FAIL sat_step%0d: got %0d/%0d want %0d/%0d", i,
                         stall_s, StallCycles, m_stall4, m_stall);
            end
        end
        n_tests++;
        if (stall_s !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d want 15", stall_s);
        end
        idle_inputs();
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            ID_rs = 5'($urandom_range(0, 3));
            ID_rt = 5'($urandom_range(0, 3));
            ID_UseRs = 1'($urandom);
            ID_UseRt = 1'($urandom);
            ID_MulDivStart = ($urandom_range(0, 7) == 0);
            EX_rs = 5'($urandom_range(0, 3));
            EX_rt = 5'($urandom_range(0, 3));
            EX_MemRead = ($urandom_range(0, 2) == 0);
            EX_RegWrite = 1'($urandom);
            EX_dst = 5'($urandom_range(0, 3));
            EX_BranchTaken = ($urandom_range(0, 5) == 0);
            MEM_RegWrite = 1'($urandom);
            MEM_dst = 5'($urandom_range(0, 3));
            WB_RegWrite = 1'($urandom);
            WB_dst = 5'($urandom_range(0, 3));
            @(negedge clk);
            compute();
            n_tests++;
            if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDivBusy} !==
                {e_pc, e_ifw, e_iff, e_idf, e_busy}) begin
                n_fail++;
                $display("FAIL rnd_ctrl%0d: got %b want %b", i,
                         {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MulDivBusy},
                         {e_pc, e_ifw, e_iff, e_idf, e_busy});
            end
            n_tests++;
            if (ForwardA !== e_fa || ForwardB !== e_fb) begin
                n_fail++;
                $display("FAIL rnd_fwd%0d: got %b/%b want %b/%b", i,
                         ForwardA, ForwardB, e_fa, e_fb);
            end
            n_tests++;
            if (StallCycles !== 32'(m_stall) || FlushCount !== 32'(m_flush)) begin
                n_fail++;
                $display("FAIL rnd_cnt%0d: got %0d/%0d want %0d/%0d", i,
                         StallCycles, FlushCount, m_stall, m_flush);
            end
            n_tests++;
            if ({pc_s, ifw_s, iff_s, idf_s, busy_s, fa_s, fb_s, stall_s, flush_s} !==
                {e_pc, e_ifw, e_iff, e_idf, e_busy, e_fa, e_fb,
                 4'(m_stall4), 4'(m_flush4)}) begin
                n_fail++;
                $display("FAIL rnd_w4_%0d: got s=%0d f=%0d want s=%0d f=%0d", i,
                         stall_s, flush_s, m_stall4, m_flush4);
            end
            advance();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        m_busy = 0; m_stall = 0; m_flush = 0;
        m_stall4 = 0; m_flush4 = 0;
        test_reset();
        test_load_use();
        test_forwarding();
        test_muldiv();
        test_branch_priority();
        test_branch_during_busy();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
